in_stream_arbiter: RTL

- Shares the single usb_cdc IN byte stream (in_data/in_valid/in_ready, app clock domain) between N_SRC byte producers, e.g. the loopback app plus a status/console source.
- Round-robin, packet-locked arbitration: a granted source owns the stream until it marks a last byte, reaches MAX_BURST bytes, or stalls past IDLE_TIMEOUT.
- Sits between the producers and usb_cdc in the top level; runs entirely on the app clock.

---
 rtl/usb_arb_pkg.sv | 21 ++
 rtl/in_stream_arbiter_rr_picker.sv | 30 +++
 rtl/in_stream_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and helpers for the usb_cdc IN-side stream arbiter.
// Holds the FSM encoding, clog2 and default counter widths.
package usb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  localparam int DEF_MAX_BURST    = 8;
  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int BEAT_W = clog2(DEF_MAX_BURST + 1);
  localparam int TO_W   = clog2(DEF_IDLE_TIMEOUT + 1);

endpackage

// File: rtl/in_stream_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; one-hot gnt and found flag out.
module rr_picker
  import usb_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          found
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing the usb_cdc IN stream.
// Ports: clk_i/rst_i, per-source data/valid/last/ready, IN stream, grant_o, busy_o.
module in_stream_arbiter
  import usb_arb_pkg::*;
#(
  parameter int N_SRC        = 2,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*N_SRC-1:0] src_data_i,
  input  logic [N_SRC-1:0]   src_valid_i,
  input  logic [N_SRC-1:0]   src_last_i,
  output logic [N_SRC-1:0]   src_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic               busy_o
);

  localparam int IW = clog2(N_SRC);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = clog2(IDLE_TIMEOUT + 1);

  arb_state_t state_q, state_d;

  logic [N_SRC-1:0] grant_q;
  logic [IW-1:0]    own_q;
  logic [IW-1:0]    ptr_q;
  logic [BW-1:0]    beat_q;
  logic [TW-1:0]    to_q;

  logic [N_SRC-1:0] pick;
  logic             found;
  logic [IW-1:0]    pick_idx;

  logic valid_g;
  logic last_g;
  logic xfer;
  logic rel;

  rr_picker #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req   (src_valid_i),
    .ptr   (ptr_q),
    .gnt   (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_SRC; i++)
      if (pick[i]) pick_idx = pick_idx | IW'(i);
  end

  assign valid_g = src_valid_i[own_q];
  assign last_g  = src_last_i[own_q];
  assign xfer    = valid_g & in_ready_i;

  // Timeout fires on the edge where the idle count would reach the limit.
  always_comb begin
    rel = 1'b0;
    if (xfer && (last_g || beat_q == BW'(MAX_BURST - 1)))
      rel = 1'b1;
    if (!valid_g && to_q == TW'(IDLE_TIMEOUT - 1))
      rel = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (found) state_d = ST_GRANT;
      ST_GRANT: if (rel)   state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_data_o   = '0;
    in_valid_o  = 1'b0;
    src_ready_o = '0;
    if (state_q == ST_GRANT) begin
      in_data_o          = src_data_i[{own_q, 3'b000} +: 8];
      in_valid_o         = valid_g;
      src_ready_o[own_q] = in_ready_i;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_GRANT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      to_q    <= '0;
    end else if (state_q == ST_IDLE) begin
      beat_q <= '0;
      to_q   <= '0;
      if (found) begin
        grant_q <= pick;
        own_q   <= pick_idx;
      end
    end else if (rel) begin
      grant_q <= '0;
      ptr_q   <= (own_q == IW'(N_SRC - 1)) ? '0 : own_q + 1'b1;
    end else begin
      if (xfer)    beat_q <= beat_q + 1'b1;
      if (valid_g) to_q   <= '0;
      else         to_q   <= to_q + 1'b1;
    end
  end

endmodule
